// File: rtl/custom_reg_sequencer.sv
// Round-robin access controller for the custom register IP: arbitrates single-word
// read/write requests and sequences them onto the IP's reg2ip/ip2reg interface.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | arbitrate; grant the winner and latch its request
// WRITE     | pulse reg2ip_en for the latched register
// READ_WAIT | wait for ip2reg_en of the latched register, or time out
// RESP      | one-cycle rvalid to the owner, then back to IDLE
module custom_reg_sequencer #(
    parameter int NUM_REQ    = 3,
    parameter int NUM_REGS   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    localparam int AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             we_i,
    input  logic [NUM_REQ*AW-1:0]          addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           err_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg2ip_data_o,
    output logic [NUM_REGS-1:0]            reg2ip_en_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ip2reg_data_i,
    input  logic [NUM_REGS-1:0]            ip2reg_en_i
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;

    state_t                               state_q, state_d;
    logic [OW-1:0]                        last_owner_q, owner_q, sel;
    logic [AW-1:0]                        addr_q, sel_addr;
    logic [CW-1:0]                        cnt_q;
    logic [DATA_WIDTH-1:0]                rdata_q, sel_wdata, rd_word;
    logic                                 err_q, sel_we, any_req, addr_bad, rd_valid, timed_out;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  r2i_q;

    // Search starts just after the last owner and wraps, so every requester
    // waits at most NUM_REQ-1 arbitrations.
    function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [OW-1:0]      last);
        logic [OW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && req[OW'(idx)]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
        return pick;
    endfunction

    assign any_req   = |req_i;
    assign sel       = rr_pick(req_i, last_owner_q);
    assign sel_we    = we_i[sel];
    assign sel_addr  = addr_i[sel*AW +: AW];
    assign sel_wdata = wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
    assign addr_bad  = ({1'b0, sel_addr} >= (AW+1)'(NUM_REGS));
    assign rd_valid  = ip2reg_en_i[addr_q];
    assign rd_word   = ip2reg_data_i[addr_q*DATA_WIDTH +: DATA_WIDTH];
    assign timed_out = (cnt_q == CW'(TIMEOUT));

    assign reg2ip_data_o = r2i_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (addr_bad)    state_d = RESP;
                    else if (sel_we) state_d = WRITE;
                    else             state_d = READ_WAIT;
                end
            end
            WRITE:     state_d = RESP;
            READ_WAIT: if (rd_valid || timed_out) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_o       = '0;
        rvalid_o    = '0;
        reg2ip_en_o = '0;
        rdata_o     = '0;
        err_o       = 1'b0;
        case (state_q)
            IDLE:  if (any_req && rst_ni) gnt_o[sel] = 1'b1;
            WRITE: reg2ip_en_o[addr_q] = 1'b1;
            RESP: begin
                rvalid_o[owner_q] = 1'b1;
                rdata_o           = rdata_q;
                err_o             = err_q;
            end
            default: ;
        endcase
    end

    // The write value lands in reg2ip_data on the grant edge so it is already
    // valid in the strobe cycle; it then holds until the next write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_owner_q <= OW'(NUM_REQ - 1);
            owner_q      <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            r2i_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= sel;
                        addr_q  <= sel_addr;
                        err_q   <= addr_bad;
                        rdata_q <= '0;
                        if (sel_we && !addr_bad) r2i_q[sel_addr] <= sel_wdata;
                    end
                end
                READ_WAIT: begin
                    if (rd_valid) begin
                        rdata_q <= rd_word;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    last_owner_q <= owner_q;
                    cnt_q        <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/custom_reg_sequencer.md
# custom_reg_sequencer

Round-robin access controller for the custom register IP. It arbitrates single-word read/write requests from several bus-side requesters, for example the AXI slave shim, a debug port and a DMA config engine. It sequences each granted request onto the IP's per-register write-strobe (`reg2ip`) and readback (`ip2reg`) interface, then returns a one-cycle response to the owning requester. It sits between the peripheral interconnect and the custom IP, and is the only block that drives the IP's `reg2ip` inputs.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `NUM_REGS`, default 3: number of IP registers.
- `DATA_WIDTH`, default 32: register width.
- `TIMEOUT`, default 16: maximum cycles to wait for readback valid, ≥1.
- `AW`: `$clog2(NUM_REGS)`, derived localparam.

Ports:
- `clk_i`  in  1  clock; everything is on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  NUM_REQ  per-requester request.
- `we_i`  in  NUM_REQ  1 = write, 0 = read.
- `addr_i`  in  NUM_REQ×AW  register index.
- `wdata_i`  in  NUM_REQ×DATA_WIDTH  write data.
- `gnt_o`  out  NUM_REQ  one-hot accept pulse.
- `rvalid_o`  out  NUM_REQ  one-hot response pulse.
- `rdata_o`  out  DATA_WIDTH  read data, shared and qualified by `rvalid_o`.
- `err_o`  out  1  error flag, qualified by `rvalid_o`.
- `reg2ip_data_o`  out  NUM_REGS×DATA_WIDTH  per-register write value; holds the last write.
- `reg2ip_en_o`  out  NUM_REGS  per-register write strobe.
- `ip2reg_data_i`  in  NUM_REGS×DATA_WIDTH  per-register readback.
- `ip2reg_en_i`  in  NUM_REGS  per-register readback valid.

## Operation
- FSM states: IDLE, WRITE, READ_WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_i` is high, select the requester with round-robin priority. Search starts at `last_owner+1` and wraps modulo NUM_REQ.
  - `last_owner` resets to NUM_REQ-1, so requester 0 wins first.
  - `gnt_o[sel]` is asserted combinationally in this cycle.
  - Latch `owner`, `we`, `addr` and `wdata` from the selected requester.
  - Next state:
    - `addr ≥ NUM_REGS` → RESP with error.
    - `we = 1` → WRITE.
    - Otherwise → READ_WAIT.
- **WRITE**
  - Drive `reg2ip_en_o[addr]` = 1 for exactly this cycle.
  - `reg2ip_data_o[addr]` is registered from `wdata` on entry, so the data is valid in the same cycle as the strobe.
  - → RESP with `err` = 0 and `rdata` = 0.
- **READ_WAIT**
  - Each cycle, if `ip2reg_en_i[addr]` is high, capture `ip2reg_data_i[addr]` → RESP with `err` = 0.
  - Otherwise increment the wait counter (`$clog2(TIMEOUT+1)` bits).
  - When the counter reaches TIMEOUT → RESP with `err` = 1 and `rdata` = 0.
  - Other registers' `ip2reg_en_i` bits are ignored.
- **RESP**
  - `rvalid_o[owner]` = 1 for one cycle, with `rdata_o` and `err_o` driven.
  - Set `last_owner` = `owner`, clear the wait counter, → IDLE.
- Requester rules:
  - Holds `req`, `we`, `addr` and `wdata` stable until `gnt`.
  - May drop `req` before grant with no effect.
  - Must not expect `gnt` outside IDLE.
- Reset values:
  - `gnt_o`, `rvalid_o`, `reg2ip_en_o`, `err_o` = 0.
  - `rdata_o` = 0.
  - `reg2ip_data_o` = all 0.
  - Wait counter = 0.

## Timing
- Grant is at cycle T, the cycle IDLE sees the request.
- Write latency:
  - `reg2ip_en_o` at T+1.
  - `rvalid_o` at T+2.
- Read latency with `ip2reg_en_i` already high:
  - Capture at T+1.
  - `rvalid_o` at T+2.
- Read latency with valid arriving k cycles late: `rvalid_o` at T+2+k.
- Read timeout: `rvalid_o` with error at T+2+TIMEOUT.
- Bad address: `rvalid_o` with error at T+1.
- Maximum throughput is one transaction per 3 cycles. Back-to-back grants are separated by the response cycle. The next grant can occur in the cycle after RESP.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester loses at most NUM_REQ-1 consecutive arbitrations.
- `rst_ni` low mid-transaction:
  - Aborts immediately and asynchronously.
  - No `rvalid` is issued and any pending strobe is dropped.
  - Arbitration resumes from requester 0.

## Test plan
- **Reset.** Hold `rst_ni` = 0 with random inputs, then release. Required: all outputs 0, and the first request from req 1 alone gets `gnt_o` = 3'b010 in the same cycle.
- **Write.** Req 0 writes addr 2 with 32'hCAFE_F00D. Required:
  - `gnt_o` = 001 at T.
  - `reg2ip_en_o` = 3'b100 and `reg2ip_data_o[2]` = CAFE_F00D at T+1.
  - `rvalid_o` = 001 with `err` = 0 at T+2.
  - `reg2ip_data_o[2]` holds its value afterwards.
- **Read with delay.** Req 2 reads addr 1; the IP raises `ip2reg_en_i[1]` with 32'h1234_5678 three cycles after grant, and `ip2reg_en_i[0]` stays high throughout. Required: `rvalid_o` = 100 and `rdata_o` = 1234_5678 at T+4, with no early capture from reg 0.
- **Fairness.** All three requesters hold `req` continuously for 9 transactions. Required: grant order 0,1,2,0,1,2,0,1,2, with grants 3 cycles apart for writes.
- **Errors.**
  - Read of addr 3: `rvalid` with `err` = 1 and `rdata` = 0 at T+1, and no `reg2ip_en_o` pulse.
  - Read of addr 0 with `ip2reg_en_i` never high and TIMEOUT = 16: `err` = 1 at T+18.
- **Reset mid-read.** Assert `rst_ni` = 0 in READ_WAIT. Required: no `rvalid_o` pulse, FSM in IDLE, and the next arbitration starts at requester 0.
